// File: rtl/clock.sv
`default_nettype none
// ============================================================================
// Module   : clock
// Brief    : Board-clock prescaler (CLK / 2^BITS) and slow-clock-aligned
//            active-high core reset generator.
// Revision : 1.0 - initial release
// ============================================================================
module clock #(
    parameter int BITS       = 24,
    parameter int RST_CYCLES = 2
) (
    input  logic CLK,
    input  logic RESET,
    output logic clk,
    output logic reset
);

    localparam int             HOLD_W    = $clog2(RST_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_CYCLES);
    localparam logic [BITS-1:0] CNT_ONE   = BITS'(1);
    localparam logic [BITS-1:0] RISE_PRE  = BITS'((64'd1 << (BITS - 1)) - 64'd1);
    localparam logic [BITS-1:0] CNT_ALL1  = '1;

    logic [BITS-1:0]   cnt;
    logic [1:0]        sync;
    logic [HOLD_W-1:0] hold;

    // Slow-clock rise: cnt steps from 0111..1 to 1000..0 on this edge.
    // Slow-clock fall: cnt wraps from all-ones to zero on this edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt   <= '0;
            sync  <= 2'b00;
            hold  <= '0;
            reset <= 1'b1;
        end else begin
            cnt  <= cnt + CNT_ONE;
            sync <= {sync[0], 1'b1};
            if (sync[1] && (cnt == RISE_PRE) && (hold != HOLD_MAX))
                hold <= hold + HOLD_W'(1);
            // Releasing on a falling slow edge gives the core half a slow period of setup.
            if ((cnt == CNT_ALL1) && (hold == HOLD_MAX))
                reset <= 1'b0;
        end
    end

    assign clk = cnt[BITS-1];

endmodule
`default_nettype wire

// File: tb/tb_clock.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock
// Brief    : Scoreboard bench for clock; three prescaler configurations share
//            one board clock and board reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    logic clk2, reset2, clk3, reset3, clk4, reset4;
    logic [5:0] act;

    always #5 CLK = ~CLK;

    clock #(.BITS(2), .RST_CYCLES(2)) u_b2 (.CLK(CLK), .RESET(RESET), .clk(clk2), .reset(reset2));
    clock #(.BITS(3), .RST_CYCLES(2)) u_b3 (.CLK(CLK), .RESET(RESET), .clk(clk3), .reset(reset3));
    clock #(.BITS(4), .RST_CYCLES(3)) u_b4 (.CLK(CLK), .RESET(RESET), .clk(clk4), .reset(reset4));

    assign act = {clk2, reset2, clk3, reset3, clk4, reset4};

    typedef struct {
        string      name;
        int         k;
        logic [5:0] exp;
    } item_t;

    item_t sbq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    core_rises = 0;
    bit    core_en = 1'b0;
    event  async_ev;

    // Expected outputs after CLK edge k counted from RESET release.
    // BITS=2/RST=2: reset falls at edge 12; BITS=3/RST=2: edge 16;
    // BITS=4/RST=3: slow rises at 8,24,40 fill hold, falls at edge 48.
    function automatic logic [5:0] exp_vec(int k, bit held);
        logic [5:0] v;
        if (held) begin
            v = 6'b010101;
        end else begin
            v[5] = ((k % 4) >= 2);
            v[4] = (k < 12);
            v[3] = ((k % 8) >= 4);
            v[2] = (k < 16);
            v[1] = ((k % 16) >= 8);
            v[0] = (k < 48);
        end
        return v;
    endfunction

    task automatic check(string name, int k, logic [5:0] actual, logic [5:0] required);
        n_cmp++;
        if (actual !== required) begin
            n_bad++;
            $display("FAIL %s k=%0d actual=%b required=%b", name, k, actual, required);
        end
    endtask

    task automatic push(string name, int k, bit held);
        item_t it;
        it.name = name;
        it.k    = k;
        it.exp  = exp_vec(k, held);
        sbq.push_back(it);
    endtask

    task automatic run_edges(string name, int n);
        for (int k = 1; k <= n; k++) begin
            @(posedge CLK);
            push(name, k, 1'b0);
        end
    endtask

    task automatic hold_low(string name, int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            push(name, 0, 1'b1);
        end
    endtask

    // Core view: slow rising edges of the BITS=4 instance that still see reset.
    always @(posedge clk4) begin
        if (core_en && reset4)
            core_rises++;
    end

    initial begin : monitor
        item_t it;
        forever begin
            @(negedge CLK or async_ev);
            if (sbq.size() > 0) begin
                it = sbq.pop_front();
                check(it.name, it.k, act, it.exp);
            end
        end
    end

    initial begin : stimulus
        hold_low("rst_state", 3);
        @(negedge CLK);
        #1 RESET = 1'b1;
        core_en = 1'b1;
        run_edges("release", 100);
        core_en = 1'b0;
        check("core_view", 0, 6'(core_rises), 6'd3);

        // Sub-cycle glitch: must force full reset and restart the sequence.
        @(negedge CLK);
        #1 RESET = 1'b0;
        #1 push("glitch_async", 0, 1'b1);
        -> async_ev;
        #1 RESET = 1'b1;
        run_edges("restart", 40);

        // Mid-cycle assertion at edge 40 takes effect before the next CLK edge.
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1 push("async_assert", 0, 1'b1);
        -> async_ev;
        hold_low("assert_hold", 3);
        @(negedge CLK);
        #1 RESET = 1'b1;
        run_edges("wrap", 1000);

        @(negedge CLK);
        #1;
        check("sb_drain", 0, 6'(sbq.size()), 6'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
